// File: rtl/wave_sched_pkg.sv
// wave_sched_pkg: shared types and constants for the waveform burst scheduler.
// Latency: n/a (types, constants and a pure LFSR step function).
// Backpressure: n/a.
package wave_sched_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_XZ   = 2'd3
    } wave_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
    localparam logic [31:0] DOWN_INIT = 32'hFFFF_FFFF;

    // Right-shifting Galois step; bit 31 is in the tap mask, so a shifted-out 1
    // always leaves a nonzero state and the all-zero lockup state is unreachable.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/wave_rr_arb.sv
// wave_rr_arb: picks the first active requester at or after the round-robin pointer.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module wave_rr_arb
#(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic [IDW-1:0]  grant_o,
    output logic            any_o
);

    // Scan from the farthest candidate back to the pointer so the closest
    // active requester is the last (winning) assignment.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid_i[IDW'((int'(rr_ptr_i) + i) % NREQ)]) begin
                grant_o = IDW'((int'(rr_ptr_i) + i) % NREQ);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_burst_sched.sv
// wave_burst_sched: round-robin owner of one shared up/down/LFSR sample generator (X/Z mode 3 under WAVE_XZ_INJECT_EN).
// Latency: grant pulse and first sample registered one cycle after req_valid; one dead GAP cycle ends each burst.
// Backpressure: samp_ready low freezes samp_data/samp_last/samp_id and the generators; all outputs registered.
module wave_burst_sched
    import wave_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 32,
    parameter int LEN_W = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_mode,
    input  logic [LEN_W*NREQ-1:0] req_len,
    output logic [NREQ-1:0]       req_ready,
    output logic                  samp_valid,
    input  logic                  samp_ready,
    output logic [DW-1:0]         samp_data,
    output logic                  samp_last,
    output logic [IDW-1:0]        samp_id,
    output logic                  busy
);

    sched_state_e   state_q;
    wave_mode_e     mode_q;
    logic [LEN_W:0] remain_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [31:0]    up_q, down_q, lfsr_q;
    logic [31:0]    up_d, down_d, lfsr_d;
`ifdef WAVE_XZ_INJECT_EN
    logic [1:0]     phase_q, phase_d;
`endif
    logic [NREQ-1:0] req_ready_q;
    logic            samp_valid_q, samp_last_q, busy_q;
    logic [DW-1:0]   samp_data_q, data_d;
    logic [IDW-1:0]  samp_id_q;

    logic [IDW-1:0]  grant;
    logic            grant_any;
    wave_mode_e      sel_mode, next_mode;
    logic [LEN_W-1:0] sel_len;
    logic [LEN_W:0]  len_eff;
    logic            fire;

    wave_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .any_o       (grant_any)
    );

    assign sel_mode  = wave_mode_e'(req_mode[2*int'(grant) +: 2]);
    assign sel_len   = req_len[LEN_W*int'(grant) +: LEN_W];
    // A zero length field means the full 2^LEN_W burst.
    assign len_eff   = {(sel_len == '0), sel_len};
    assign fire      = (state_q == ST_RUN) && samp_valid_q && samp_ready;
    assign next_mode = (state_q == ST_IDLE) ? sel_mode : mode_q;

    // Advance only the generator owned by the accepted sample's mode.
    always_comb begin
        up_d   = up_q;
        down_d = down_q;
        lfsr_d = lfsr_q;
`ifdef WAVE_XZ_INJECT_EN
        phase_d = phase_q;
`endif
        if (fire) begin
            case (mode_q)
                MODE_UP:   up_d   = up_q + 32'd1;
                MODE_DOWN: down_d = down_q - 32'd1;
`ifdef WAVE_XZ_INJECT_EN
                MODE_XZ: begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q[1]) lfsr_d = lfsr_step(lfsr_q);
                end
`endif
                default:   lfsr_d = lfsr_step(lfsr_q);
            endcase
        end
    end

    // Next sample to present, taken from the post-advance generator state.
    always_comb begin
        data_d = lfsr_d[DW-1:0];
        case (next_mode)
            MODE_UP:   data_d = up_d[DW-1:0];
            MODE_DOWN: data_d = down_d[DW-1:0];
`ifdef WAVE_XZ_INJECT_EN
            MODE_XZ: begin
                case (phase_d)
                    2'd0:    data_d = {DW{1'bx}};
                    2'd1:    data_d = {DW{1'bz}};
                    2'd2:    data_d = {lfsr_d[DW-1:1], 1'bx};
                    default: data_d = {lfsr_d[DW-1:1], 1'bz};
                endcase
            end
`endif
            default:   data_d = lfsr_d[DW-1:0];
        endcase
    end

    // Scheduler FSM with registered outputs and shared generator state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_UP;
            remain_q     <= '0;
            rr_ptr_q     <= '0;
            up_q         <= '0;
            down_q       <= DOWN_INIT;
            lfsr_q       <= LFSR_SEED;
`ifdef WAVE_XZ_INJECT_EN
            phase_q      <= '0;
`endif
            req_ready_q  <= '0;
            samp_valid_q <= 1'b0;
            samp_data_q  <= '0;
            samp_last_q  <= 1'b0;
            samp_id_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            req_ready_q <= '0;
            up_q        <= up_d;
            down_q      <= down_d;
            lfsr_q      <= lfsr_d;
`ifdef WAVE_XZ_INJECT_EN
            phase_q     <= phase_d;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        state_q      <= ST_RUN;
                        mode_q       <= sel_mode;
                        remain_q     <= len_eff;
                        req_ready_q  <= NREQ'(1) << grant;
                        samp_valid_q <= 1'b1;
                        samp_data_q  <= data_d;
                        samp_last_q  <= (len_eff == (LEN_W+1)'(1));
                        samp_id_q    <= grant;
                        busy_q       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        if (remain_q == (LEN_W+1)'(1)) begin
                            state_q      <= ST_GAP;
                            samp_valid_q <= 1'b0;
                            samp_last_q  <= 1'b0;
                            rr_ptr_q     <= (samp_id_q == IDW'(NREQ-1)) ? '0 : samp_id_q + IDW'(1);
                        end else begin
                            remain_q    <= remain_q - (LEN_W+1)'(1);
                            samp_data_q <= data_d;
                            samp_last_q <= (remain_q == (LEN_W+1)'(2));
                        end
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign samp_valid = samp_valid_q;
    assign samp_data  = samp_data_q;
    assign samp_last  = samp_last_q;
    assign samp_id    = samp_id_q;
    assign busy       = busy_q;

endmodule

// File: doc/wave_burst_sched.md
# wave_burst_sched

Round-robin scheduler that shares one waveform-sample pattern generator between several stimulus requesters. Each requester asks for a burst of N samples in one pattern mode: up-counter, down-counter, LFSR random, or X/Z injection. The block arbitrates, runs the burst with sink backpressure, marks the last sample, and tags each sample with the owner's index. It sits between testbench stimulus agents and the sampled-signal sinks of the waveform-sample design.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DW`, 32: sample width (8..32).
- `LEN_W`, 8: burst-length field width.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: per-requester burst request; held until accepted.
- `req_mode` in 2*NREQ: per-requester mode. 0 = up-counter, 1 = down-counter, 2 = LFSR, 3 = X/Z.
- `req_len` in LEN_W*NREQ: per-requester burst length. 0 means 2^LEN_W.
- `req_ready` out NREQ: one-cycle accept pulse, one-hot.
- `samp_valid` out 1: sample present.
- `samp_ready` in 1: sink accepts the sample.
- `samp_data` out DW: sample value.
- `samp_last` out 1: final sample of the burst.
- `samp_id` out $clog2(NREQ): owning requester.
- `busy` out 1: a burst is in progress.

## Operation
- FSM states: IDLE, RUN, GAP.
  - IDLE: if any `req_valid` is high, grant the first requester at or after `rr_ptr`. Latch its mode and length, pulse `req_ready[g]`, go to RUN.
  - RUN: present a sample. On each `samp_valid && samp_ready`, decrement `remain` and advance the generator.
  - When the last sample is accepted: `rr_ptr <= g+1` (mod NREQ), go to GAP.
  - GAP: one dead cycle, then IDLE.
- Stall rule: while `samp_ready` is low, `samp_data`, `samp_last` and `samp_id` hold stable.
- `samp_last` = (`remain` == 1) while in RUN.
- Generators use one shared state across all bursts and all requesters.
  - Up-counter: 32-bit, reset 0, +1 per accepted mode-0 sample, wraps from FFFF_FFFF to 0.
  - Down-counter: 32-bit, reset FFFF_FFFF, -1 per accepted mode-1 sample, wraps from 0 to FFFF_FFFF.
  - LFSR: 32-bit Galois, taps mask 0x8020_0003, reset seed 0xACE1_0001, steps per accepted mode-2 sample. It never reaches zero.
  - `samp_data` is the low DW bits of the selected generator.
- Requesters must hold `req_mode` and `req_len` stable while `req_valid` is high. Dropping `req_valid` before accept is allowed: no grant.
- Reset values: `req_ready`=0, `samp_valid`=0, `samp_data`=0, `samp_last`=0, `samp_id`=0, `busy`=0, `rr_ptr`=0, state=IDLE, generators at their reset values.
- Reset mid-burst aborts immediately. No `samp_last` is issued, and the requester is not re-notified.

## Timing
- `req_valid` high before edge t in IDLE:
  - `req_ready[g]` high for one cycle after edge t.
  - `samp_valid` high from edge t, so the first sample is visible 1 cycle after the request.
- Burst of length L with `samp_ready` tied high: L consecutive valid cycles, then 1 GAP cycle, then IDLE.
- Minimum request-to-request spacing is L+2 cycles.
- `busy` is high in RUN and GAP.
- All outputs are registered. There is no combinational path from `samp_ready` or `req_valid` to any output.

## Configuration
- `WAVE_XZ_INJECT_EN` defined: mode 3 drives a four-value pattern.
  - An internal 4-phase counter steps per accepted sample: full X, full Z, LFSR data with bit 0 = X, LFSR data with bit 0 = Z.
  - The LFSR advances on phases 2 and 3.
- `WAVE_XZ_INJECT_EN` undefined: mode 3 is treated as mode 2 (LFSR), and all outputs are strictly 2-state.

## Structure
- Package `wave_sched_pkg`:
  - Mode enum `wave_mode_e` (MODE_UP, MODE_DOWN, MODE_LFSR, MODE_XZ).
  - FSM enum `sched_state_e`.
  - `LFSR_TAPS`, `LFSR_SEED`, `DOWN_INIT` constants.
- Sub-module `wave_rr_arb`: combinational round-robin picker. Inputs are the `req_valid` vector and `rr_ptr`; outputs are the grant index and `any`.
- Generators and FSM live in the top module.

## Test plan
- Single request, requester 0, mode 0, len 4, sink always ready after reset -> data 0,1,2,3; `samp_last` on the 4th; `req_ready[0]` one pulse; `busy` for 5 cycles.
- Requesters 0 and 2 both request at once, len 1, repeated 4 times -> grant order 0,2,0,2; `samp_id` matches each grant.
- Mode 1, len 0 with LEN_W=8, sink random-stall 50% -> exactly 256 samples FFFF_FFFF..FFFF_FF00; data stable during stalls; one `samp_last`.
- Mode 2, len 3 -> 0xACE1_0001 followed by two further LFSR steps matching the reference model.
- `reset_n` low mid-burst at sample 2 of 5 -> all outputs 0 the same cycle; after release, mode 0 restarts at 0.
- Mode 3, len 4 -> with `WAVE_XZ_INJECT_EN`: X, Z, {lfsr,X}, {lfsr,Z}; without it: four LFSR values, no X/Z on `samp_data`.
